// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if
// Request/response bundle between the core's execute stage (master) and the
// data memory (slave).
//   dmem_address      byte address
//   dmem_enable       request strobe
//   dmem_write_data   store data, right-aligned
//   dmem_write_enable store request
//   dmem_write_mode   000 byte, 001 half, 010 word
//   dmem_read_enable  load request
//   dmem_read_mode    000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
//   dmem_read_data    load data, right-aligned, no extension
//   dmem_wait         access outstanding
// -----------------------------------------------------------------------------
interface dmem_if;
   logic [31:0] dmem_address;
   logic        dmem_enable;
   logic [31:0] dmem_write_data;
   logic        dmem_write_enable;
   logic [2:0]  dmem_write_mode;
   logic        dmem_read_enable;
   logic [2:0]  dmem_read_mode;
   logic [31:0] dmem_read_data;
   logic        dmem_wait;

   modport master (
      output dmem_address, dmem_enable, dmem_write_data, dmem_write_enable,
             dmem_write_mode, dmem_read_enable, dmem_read_mode,
      input  dmem_read_data, dmem_wait
   );

   modport slave (
      input  dmem_address, dmem_enable, dmem_write_data, dmem_write_enable,
             dmem_write_mode, dmem_read_enable, dmem_read_mode,
      output dmem_read_data, dmem_wait
   );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory slave for the core's dmem interface. One request is captured per
// accepted edge, stores are byte-lane masked, loads return the addressed word
// shifted right by 8*address[1:0] (extension is done in writeback). LATENCY
// wait cycles are inserted per access via dmem_wait. Misaligned or reserved
// accesses are suppressed (loads return 0) and set a sticky flag.
//   clk        clock
//   reset_n    asynchronous active-low reset
//   bus        dmem_if slave modport
//   misaligned sticky misalignment flag, cleared only by reset
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LATENCY    = 0
) (
   input  logic   clk,
   input  logic   reset_n,
   dmem_if.slave  bus,
   output logic   misaligned
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam int unsigned     AW       = ADDR_WIDTH + 2;
   localparam logic [3:0]      CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

   state_t          state_q;
   logic [3:0]      cnt_q;
   logic            wait_q;
   logic [31:0]     rdata_q;
   logic            mis_q;
   logic [AW-1:0]   addr_q;
   logic [31:0]     wdata_q;
   logic            we_q;
   logic            re_q;
   logic [2:0]      wmode_q;
   logic [2:0]      rmode_q;

   logic [31:0]     mem_q [2**ADDR_WIDTH];

   logic            accept;
   logic            exec;
   logic [AW-1:0]   e_addr;
   logic [31:0]     e_wdata;
   logic            e_we;
   logic            e_re;
   logic [2:0]      e_wmode;
   logic [2:0]      e_rmode;
   logic            mis;
   logic [3:0]      be;
   logic [31:0]     wlanes;
   logic [31:0]     rd_shift;
   logic            mem_we;
   logic            unused_addr_bits;

   assign unused_addr_bits = ^bus.dmem_address[31:AW];

   assign accept = (state_q == IDLE) && bus.dmem_enable &&
                   (bus.dmem_read_enable || bus.dmem_write_enable);

   // With no latency the access executes straight from the bus on the accept
   // edge; otherwise it executes from the request registers when the count ends.
   always_comb begin
      if (LATENCY == 0) begin
         exec    = accept;
         e_addr  = bus.dmem_address[AW-1:0];
         e_wdata = bus.dmem_write_data;
         e_we    = bus.dmem_write_enable;
         e_re    = bus.dmem_read_enable;
         e_wmode = bus.dmem_write_mode;
         e_rmode = bus.dmem_read_mode;
      end else begin
         exec    = (state_q == BUSY) && (cnt_q == '0);
         e_addr  = addr_q;
         e_wdata = wdata_q;
         e_we    = we_q;
         e_re    = re_q;
         e_wmode = wmode_q;
         e_rmode = rmode_q;
      end
   end

   // Alignment check, lane enables and lane-replicated store data.
   always_comb begin
      mis    = 1'b0;
      be     = '0;
      wlanes = e_wdata;
      if (e_we) begin
         case (e_wmode)
            3'b000: begin
               be     = 4'b0001 << e_addr[1:0];
               wlanes = {4{e_wdata[7:0]}};
            end
            3'b001: begin
               mis    = e_addr[0];
               be     = e_addr[1] ? 4'b1100 : 4'b0011;
               wlanes = {2{e_wdata[15:0]}};
            end
            3'b010: begin
               mis = (e_addr[1:0] != 2'b00);
               be  = 4'b1111;
            end
            default: mis = 1'b1;
         endcase
      end else begin
         case (e_rmode)
            3'b000, 3'b100: mis = 1'b0;
            3'b001, 3'b101: mis = e_addr[0];
            3'b010:         mis = (e_addr[1:0] != 2'b00);
            default:        mis = 1'b1;
         endcase
      end
   end

   assign rd_shift = mem_q[e_addr[AW-1:2]] >> {e_addr[1:0], 3'b000};
   assign mem_we   = exec && e_we && !mis && reset_n;

   // Array is not reset; contents survive reset_n.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) mem_q[e_addr[AW-1:2]][8*b +: 8] <= wlanes[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wait_q  <= 1'b0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         wmode_q <= '0;
         rmode_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept && (LATENCY != 0)) begin
                  state_q <= BUSY;
                  cnt_q   <= CNT_INIT;
                  wait_q  <= 1'b1;
                  addr_q  <= bus.dmem_address[AW-1:0];
                  wdata_q <= bus.dmem_write_data;
                  we_q    <= bus.dmem_write_enable;
                  re_q    <= bus.dmem_read_enable;
                  wmode_q <= bus.dmem_write_mode;
                  rmode_q <= bus.dmem_read_mode;
               end
            end
            BUSY: begin
               if (cnt_q == '0) begin
                  state_q <= IDLE;
                  wait_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase

         // Read+write together is a write only; read data untouched.
         if (exec) begin
            if (mis) mis_q <= 1'b1;
            if (!e_we && e_re) rdata_q <= mis ? '0 : rd_shift;
         end
      end
   end

   assign bus.dmem_read_data = rdata_q;
   assign bus.dmem_wait      = wait_q;
   assign misaligned         = mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [31:0] addr, wdata;
   logic        we, re, en0, en3;
   logic [2:0]  wm, rm;
   logic        mis0, mis3;

   dmem_if bus0();
   dmem_if bus3();

   assign bus0.dmem_address      = addr;
   assign bus0.dmem_enable       = en0;
   assign bus0.dmem_write_data   = wdata;
   assign bus0.dmem_write_enable = we;
   assign bus0.dmem_write_mode   = wm;
   assign bus0.dmem_read_enable  = re;
   assign bus0.dmem_read_mode    = rm;
   assign bus3.dmem_address      = addr;
   assign bus3.dmem_enable       = en3;
   assign bus3.dmem_write_data   = wdata;
   assign bus3.dmem_write_enable = we;
   assign bus3.dmem_write_mode   = wm;
   assign bus3.dmem_read_enable  = re;
   assign bus3.dmem_read_mode    = rm;

   dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut0 (
      .clk(clk), .reset_n(rst_n), .bus(bus0), .misaligned(mis0));
   dmem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut3 (
      .clk(clk), .reset_n(rst_n), .bus(bus3), .misaligned(mis3));

   // Reference model: byte-addressed 4 KiB memory (10-bit word index wraps).
   logic [7:0]  mb [4096];
   logic [31:0] exp_rd;
   logic        exp_mis;
   int          n_tests, n_fail;
   logic        wait0_seen;

   always @(negedge clk) if (bus0.dmem_wait === 1'b1) wait0_seen = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int unsigned mode_size(input logic [2:0] m, input logic is_read);
      case (m)
         3'b000:  return 1;
         3'b001:  return 2;
         3'b010:  return 4;
         3'b100:  return is_read ? 1 : 0;
         3'b101:  return is_read ? 2 : 0;
         default: return 0;
      endcase
   endfunction

   function automatic void model_apply(input logic [31:0] a, input logic [31:0] d,
                                       input logic w, input logic r,
                                       input logic [2:0] wmo, input logic [2:0] rmo);
      int unsigned ba, sz, base;
      ba = int'(a[11:0]);
      if (w) begin
         sz = mode_size(wmo, 1'b0);
         if (sz == 0 || ba % sz != 0) exp_mis = 1'b1;
         else for (int unsigned k = 0; k < sz; k++) mb[ba + k] = d[8*k +: 8];
      end else if (r) begin
         sz = mode_size(rmo, 1'b1);
         if (sz == 0 || ba % sz != 0) begin
            exp_mis = 1'b1;
            exp_rd  = '0;
         end else begin
            base   = ba - ba % 4;
            exp_rd = '0;
            for (int unsigned k = ba; k < base + 4; k++)
               exp_rd = exp_rd | (32'(mb[k]) << (8 * (k - ba)));
         end
      end
   endfunction

   // Drive one request to both responders, wait for the slow one, check both.
   task automatic access(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input logic r, input logic [2:0] wmo, input logic [2:0] rmo);
      int n;
      @(negedge clk);
      addr = a; wdata = d; we = w; re = r; wm = wmo; rm = rmo; en0 = 1'b1; en3 = 1'b1;
      @(posedge clk); #1;
      check("wait3_after_accept", 32'(bus3.dmem_wait), 32'd1);
      check("wait0_after_accept", 32'(bus0.dmem_wait), 32'd0);
      @(negedge clk);
      en0 = 1'b0; en3 = 1'b0; we = 1'b0; re = 1'b0;
      n = 0;
      while (bus3.dmem_wait === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("wait3_cycles", 32'(n), 32'd3);
      model_apply(a, d, w, r, wmo, rmo);
      check("rdata0", bus0.dmem_read_data, exp_rd);
      check("rdata3", bus3.dmem_read_data, exp_rd);
      check("mis0", 32'(mis0), 32'(exp_mis));
      check("mis3", 32'(mis3), 32'(exp_mis));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] a, d;
      logic w, r;
      logic [2:0] wmo, rmo;
      int unsigned sz;

      n_tests = 0; n_fail = 0; wait0_seen = 1'b0;
      exp_rd = '0; exp_mis = 1'b0;
      addr = '0; wdata = '0; we = 0; re = 0; wm = '0; rm = '0; en0 = 0; en3 = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_rdata0", bus0.dmem_read_data, 32'h0);
      check("reset_rdata3", bus3.dmem_read_data, 32'h0);
      check("reset_wait3", 32'(bus3.dmem_wait), 32'd0);
      check("reset_mis3", 32'(mis3), 32'd0);

      for (int i = 16; i < 48; i++) access(32'(i * 4), $urandom, 1, 0, 3'b010, 3'b000);

      // Word, byte and half lanes
      access(32'h40, 32'hDEADBEEF, 1, 0, 3'b010, 3'b000);
      access(32'h40, 32'h0, 0, 1, 3'b000, 3'b010);
      check("lw_deadbeef", bus0.dmem_read_data, 32'hDEADBEEF);
      access(32'h41, 32'h5A, 1, 0, 3'b000, 3'b000);
      access(32'h40, 32'h0, 0, 1, 3'b000, 3'b010);
      check("lw_after_sb", bus3.dmem_read_data, 32'hDEAD5AEF);
      access(32'h43, 32'h0, 0, 1, 3'b000, 3'b000);
      check("lb_0x43", 32'(bus3.dmem_read_data[7:0]), 32'hDE);
      access(32'h42, 32'h1234, 1, 0, 3'b001, 3'b000);
      access(32'h40, 32'h0, 0, 1, 3'b000, 3'b010);
      check("lw_after_sh", bus0.dmem_read_data, 32'h12345AEF);
      access(32'h42, 32'h0, 0, 1, 3'b000, 3'b001);
      check("lh_0x42", 32'(bus3.dmem_read_data[15:0]), 32'h1234);

      // Enable pulse while busy must be ignored (slow responder only)
      @(negedge clk);
      addr = 32'h40; re = 1; we = 0; rm = 3'b010; en3 = 1;
      @(negedge clk); en3 = 0;
      @(negedge clk); re = 0; we = 1; wdata = 32'h0; wm = 3'b010; en3 = 1;
      @(negedge clk); en3 = 0; we = 0;
      n = 0;
      while (bus3.dmem_wait === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("midwait_wait_bounded", 32'(n < 20), 32'd1);
      check("midwait_rdata3", bus3.dmem_read_data, 32'h12345AEF);
      access(32'h40, 32'h0, 0, 1, 3'b000, 3'b010);

      // Misaligned store/load
      access(32'h42, 32'hFFFFFFFF, 1, 0, 3'b010, 3'b000);
      check("mis_set", 32'(mis3), 32'd1);
      access(32'h41, 32'h0, 0, 1, 3'b000, 3'b001);
      check("mis_lh_zero", bus3.dmem_read_data, 32'h0);
      access(32'h40, 32'h0, 0, 1, 3'b000, 3'b010);
      check("mis_word_kept", bus0.dmem_read_data, 32'h12345AEF);

      // Reset in the second wait cycle of a store to 0x80 (slow responder)
      @(negedge clk);
      addr = 32'h80; wdata = ~{mb[131], mb[130], mb[129], mb[128]};
      we = 1; re = 0; wm = 3'b010; en3 = 1;
      @(negedge clk); en3 = 0; we = 0;
      @(negedge clk);
      check("rst_wait_before", 32'(bus3.dmem_wait), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_wait3", 32'(bus3.dmem_wait), 32'd0);
      check("rst_rdata3", bus3.dmem_read_data, 32'h0);
      check("rst_mis3", 32'(mis3), 32'd0);
      check("rst_rdata0", bus0.dmem_read_data, 32'h0);
      exp_rd = '0; exp_mis = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      access(32'h80, 32'h0, 0, 1, 3'b000, 3'b010);

      // Random traffic, window 0x40..0xBF with random upper address bits
      for (int i = 0; i < 150; i++) begin
         w   = 1'($urandom_range(0, 1));
         r   = !w || ($urandom_range(0, 3) == 0);
         wmo = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         rmo = 3'($urandom_range(0, 7));
         a   = {20'($urandom), 12'(32'h40 + $urandom_range(0, 127))};
         sz  = mode_size(w ? wmo : rmo, !w);
         if ($urandom_range(0, 3) != 0 && sz > 1) a[1:0] = (sz == 2) ? {a[1], 1'b0} : 2'b00;
         d   = $urandom;
         access(a, d, w, r, wmo, rmo);
      end

      check("wait0_never_high", 32'(wait0_seen), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
